// File: rtl/cond_logic.sv
// Conditional-execution unit: holds the NZCV flags, tests the instruction's
// condition field against them, and gates the PC, register and memory writes.
module cond_logic (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    logic [3:0] flags_reg;
    logic       n_flag;
    logic       z_flag;
    logic       c_flag;
    logic       v_flag;
    logic       cond_pass;

    assign n_flag = flags_reg[3];
    assign z_flag = flags_reg[2];
    assign c_flag = flags_reg[1];
    assign v_flag = flags_reg[0];

    // Condition is tested against the stored flags only, so a flag-setting
    // instruction sees the values from before its own update.
    always_comb begin
        cond_pass = 1'b0;
        case (Cond)
            4'b0000: cond_pass = z_flag;
            4'b0001: cond_pass = ~z_flag;
            4'b0010: cond_pass = c_flag;
            4'b0011: cond_pass = ~c_flag;
            4'b0100: cond_pass = n_flag;
            4'b0101: cond_pass = ~n_flag;
            4'b0110: cond_pass = v_flag;
            4'b0111: cond_pass = ~v_flag;
            4'b1000: cond_pass = c_flag & ~z_flag;
            4'b1001: cond_pass = ~c_flag | z_flag;
            4'b1010: cond_pass = (n_flag == v_flag);
            4'b1011: cond_pass = (n_flag != v_flag);
            4'b1100: cond_pass = ~z_flag & (n_flag == v_flag);
            4'b1101: cond_pass = z_flag | (n_flag != v_flag);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign CondEx   = cond_pass & ~reset;
    assign PCSrc    = PCS & CondEx;
    assign RegWrite = RegW & CondEx & ~NoWrite;
    assign MemWrite = MemW & CondEx;
    assign Flags    = flags_reg;

    // Two independent halves: gi = 1 holds {N,Z}, gi = 0 holds {C,V}.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_flag_half
            logic [1:0] half_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    half_reg <= 2'b00;
                end else if (CondEx && FlagW[gi]) begin
                    half_reg <= ALUFlags[2*gi+1:2*gi];
                end
            end

            assign flags_reg[2*gi+1:2*gi] = half_reg;
        end
    endgenerate

endmodule
